// File: rtl/can_rx_fifo.sv
// CAN receive message FIFO: buffers accepted frames for the wishbone slave.
// Show-ahead head, occupancy/overrun status, synchronous software flush.
module can_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int OCC_W = 4
) (
    input  logic              CAN_clk,
    input  logic              CAN_nRST,
    input  logic              rx_pkt_valid,
    input  logic [28:0]       rx_ID,
    input  logic [3:0]        rx_pkt_size,
    input  logic              rx_RTR,
    input  logic              rx_EXT,
    input  logic [63:0]       rx_data,
    input  logic [4:0]        rx_fmi,
    input  logic              read_fifo,
    input  logic              fifo_clear,
    input  logic              overrun_enable,
    output logic [31:0]       fifo_data_L,
    output logic [31:0]       fifo_data_H,
    output logic [28:0]       fifo_ID,
    output logic [3:0]        fifo_pkt_size,
    output logic              fifo_RTR,
    output logic              fifo_EXT,
    output logic [4:0]        fifo_fmi,
    output logic [OCC_W-1:0]  fifo_occupancy,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_overrun,
    output logic              fifo_read
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = 104;

    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [OCC_W-1:0] occ;
    logic             ovr;
    logic             rd_pulse;

    logic          full;
    logic          empty;
    logic          pop_ok;
    logic          no_room;
    logic          occ_up;
    logic          wr_en;
    logic [EW-1:0] head;

    assign full    = (occ == OCC_W'(DEPTH));
    assign empty   = (occ == '0);
    assign pop_ok  = read_fifo & ~empty;
    // A full FIFO with a same-cycle pop still has room for the new frame.
    assign no_room = rx_pkt_valid & full & ~pop_ok;
    assign occ_up  = rx_pkt_valid & ~no_room;
    assign wr_en   = ~fifo_clear & (occ_up | (no_room & overrun_enable));

    always_ff @(posedge CAN_clk) begin
        if (wr_en)
            mem[wr_ptr] <= {rx_fmi, rx_EXT, rx_RTR, rx_pkt_size, rx_ID, rx_data};
    end

    always_ff @(posedge CAN_clk or negedge CAN_nRST) begin
        if (!CAN_nRST) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            ovr      <= 1'b0;
            rd_pulse <= 1'b0;
        end else if (fifo_clear) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            ovr      <= 1'b0;
            rd_pulse <= 1'b0;
        end else begin
            rd_pulse <= pop_ok;
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            // Overwrite-when-full discards the oldest entry by advancing the read side.
            if (pop_ok | (no_room & overrun_enable))
                rd_ptr <= rd_ptr + AW'(1);
            if (no_room)
                ovr <= 1'b1;
            if (occ_up & ~pop_ok)
                occ <= occ + OCC_W'(1);
            else if (~occ_up & pop_ok)
                occ <= occ - OCC_W'(1);
        end
    end

    assign head = empty ? '0 : mem[rd_ptr];

    assign fifo_fmi       = head[103:99];
    assign fifo_EXT       = head[98];
    assign fifo_RTR       = head[97];
    assign fifo_pkt_size  = head[96:93];
    assign fifo_ID        = head[92:64];
    assign fifo_data_H    = head[63:32];
    assign fifo_data_L    = head[31:0];
    assign fifo_occupancy = occ;
    assign fifo_full      = full;
    assign fifo_empty     = empty;
    assign fifo_overrun   = ovr;
    assign fifo_read      = rd_pulse;

endmodule

// File: tb/tb_can_rx_fifo.sv
// Scoreboard bench for can_rx_fifo: directed scenarios plus random traffic
// against a queue-based frame model.
module tb_can_rx_fifo;

    localparam int DEPTH = 8;
    localparam int OCC_W = 4;

    logic              CAN_clk = 1'b0;
    logic              CAN_nRST;
    logic              rx_pkt_valid;
    logic [28:0]       rx_ID;
    logic [3:0]        rx_pkt_size;
    logic              rx_RTR;
    logic              rx_EXT;
    logic [63:0]       rx_data;
    logic [4:0]        rx_fmi;
    logic              read_fifo;
    logic              fifo_clear;
    logic              overrun_enable;
    logic [31:0]       fifo_data_L;
    logic [31:0]       fifo_data_H;
    logic [28:0]       fifo_ID;
    logic [3:0]        fifo_pkt_size;
    logic              fifo_RTR;
    logic              fifo_EXT;
    logic [4:0]        fifo_fmi;
    logic [OCC_W-1:0]  fifo_occupancy;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_overrun;
    logic              fifo_read;

    can_rx_fifo #(.DEPTH(DEPTH), .OCC_W(OCC_W)) dut (
        .CAN_clk(CAN_clk), .CAN_nRST(CAN_nRST),
        .rx_pkt_valid(rx_pkt_valid), .rx_ID(rx_ID),
        .rx_pkt_size(rx_pkt_size), .rx_RTR(rx_RTR), .rx_EXT(rx_EXT),
        .rx_data(rx_data), .rx_fmi(rx_fmi),
        .read_fifo(read_fifo), .fifo_clear(fifo_clear),
        .overrun_enable(overrun_enable),
        .fifo_data_L(fifo_data_L), .fifo_data_H(fifo_data_H),
        .fifo_ID(fifo_ID), .fifo_pkt_size(fifo_pkt_size),
        .fifo_RTR(fifo_RTR), .fifo_EXT(fifo_EXT), .fifo_fmi(fifo_fmi),
        .fifo_occupancy(fifo_occupancy), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .fifo_overrun(fifo_overrun),
        .fifo_read(fifo_read)
    );

    always #5 CAN_clk = ~CAN_clk;

    int total = 0;
    int bad = 0;

    logic [103:0] model_q [$];
    logic [103:0] exp_q [$];
    bit           model_ovr;
    bit           exp_read;

    function automatic logic [103:0] mk(input logic [28:0] id,
                                        input logic [3:0] dlc,
                                        input logic rtr, input logic ext,
                                        input logic [63:0] data,
                                        input logic [4:0] fmi);
        return {fmi, ext, rtr, dlc, id, data};
    endfunction

    function automatic logic [103:0] head_now();
        return {fifo_fmi, fifo_EXT, fifo_RTR, fifo_pkt_size, fifo_ID,
                fifo_data_H, fifo_data_L};
    endfunction

    task automatic chk(input string name, input logic [103:0] act,
                       input logic [103:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must present the scoreboard's oldest frame.
    always @(negedge CAN_clk) begin
        if (CAN_nRST && read_fifo && !fifo_empty && !fifo_clear) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", 104'd1, 104'd0);
            end else begin
                chk("pop_head", head_now(), exp_q.pop_front());
            end
        end
    end

    task automatic check_status();
        int n;
        n = model_q.size();
        chk("occupancy", 104'(fifo_occupancy), 104'(n));
        chk("empty", 104'(fifo_empty), 104'(n == 0));
        chk("full", 104'(fifo_full), 104'(n == DEPTH));
        chk("overrun", 104'(fifo_overrun), 104'(model_ovr));
        chk("fifo_read", 104'(fifo_read), 104'(exp_read));
        chk("head", head_now(), (n == 0) ? 104'd0 : model_q[0]);
    endtask

    // One clock: drive inputs, advance the model, check status after the edge.
    task automatic cycle(input bit push, input logic [103:0] f,
                         input bit pop, input bit clr, input bit oe);
        bit popok;
        rx_pkt_valid   = push;
        {rx_fmi, rx_EXT, rx_RTR, rx_pkt_size, rx_ID, rx_data} = f;
        read_fifo      = pop;
        fifo_clear     = clr;
        overrun_enable = oe;
        popok = 0;
        if (clr) begin
            model_q.delete();
            model_ovr = 0;
        end else begin
            popok = pop && (model_q.size() > 0);
            if (popok) exp_q.push_back(model_q.pop_front());
            if (push) begin
                if (model_q.size() < DEPTH) begin
                    model_q.push_back(f);
                end else begin
                    model_ovr = 1;
                    if (oe) begin
                        void'(model_q.pop_front());
                        model_q.push_back(f);
                    end
                end
            end
        end
        exp_read = popok;
        @(posedge CAN_clk);
        #1;
        check_status();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, 0);
    endtask

    task automatic fill_ids();
        for (int i = 1; i <= DEPTH; i++)
            cycle(1, mk(29'(i), 4'd8, 0, 0, {32'(i), 32'hA5A5_0000 + 32'(i)}, 5'(i)), 0, 0, 0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 1, 0, 0);
    endtask

    task automatic do_reset();
        read_fifo    = 0;
        rx_pkt_valid = 0;
        fifo_clear   = 0;
        #2;
        CAN_nRST = 0;
        model_q.delete();
        exp_q.delete();
        model_ovr = 0;
        exp_read  = 0;
        #1;
        check_status();
        @(negedge CAN_clk);
        CAN_nRST = 1;
        @(posedge CAN_clk);
        #1;
    endtask

    initial begin
        logic [103:0] f;
        CAN_nRST       = 0;
        rx_pkt_valid   = 0;
        rx_ID          = '0;
        rx_pkt_size    = '0;
        rx_RTR         = 0;
        rx_EXT         = 0;
        rx_data        = '0;
        rx_fmi         = '0;
        read_fifo      = 0;
        fifo_clear     = 0;
        overrun_enable = 0;
        model_ovr      = 0;
        exp_read       = 0;
        #1;
        check_status();
        @(negedge CAN_clk);
        CAN_nRST = 1;
        @(posedge CAN_clk);
        #1;

        // Single frame: show-ahead fields, then one pop with one fifo_read pulse.
        f = mk(29'h1ABCDE5, 4'd8, 0, 1, 64'h1122334455667788, 5'd3);
        cycle(1, f, 0, 0, 0);
        chk("t1_data_L", 104'(fifo_data_L), 104'h55667788);
        chk("t1_data_H", 104'(fifo_data_H), 104'h11223344);
        chk("t1_fmi", 104'(fifo_fmi), 104'd3);
        cycle(0, '0, 1, 0, 0);
        idle(2);

        // Fill, drain in order, then pop on empty.
        fill_ids();
        drain(DEPTH);
        cycle(0, '0, 1, 0, 0);
        idle(1);

        // Full, drop newest.
        fill_ids();
        cycle(1, mk(29'd9, 4'd1, 0, 0, 64'h9, 5'd9), 0, 0, 0);
        chk("drop_head_id", 104'(fifo_ID), 104'd1);
        drain(DEPTH);
        cycle(0, '0, 0, 1, 0);

        // Full, overwrite oldest.
        fill_ids();
        cycle(1, mk(29'd9, 4'd1, 0, 0, 64'h9, 5'd9), 0, 0, 1);
        chk("ovw_head_id", 104'(fifo_ID), 104'd2);
        drain(DEPTH);
        cycle(0, '0, 0, 1, 0);

        // Full with simultaneous push and pop: no overrun.
        fill_ids();
        cycle(1, mk(29'd9, 4'd1, 0, 0, 64'h9, 5'd9), 1, 0, 0);
        chk("pp_head_id", 104'(fifo_ID), 104'd2);
        drain(DEPTH);

        // Clear with overrun set and a simultaneous push.
        for (int i = 0; i < 3; i++) cycle(1, mk(29'(i), 4'd2, 1, 0, 64'(i), 5'd1), 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(1, mk(29'(i), 4'd2, 1, 0, 64'(i), 5'd1), 0, 0, 0);
        drain(5);
        cycle(1, mk(29'h77, 4'd3, 0, 1, 64'h77, 5'd7), 0, 1, 0);
        chk("clr_empty", 104'(fifo_empty), 104'd1);

        // Asynchronous reset mid-stream.
        cycle(1, mk(29'h10, 4'd4, 0, 0, 64'hDEAD, 5'd2), 0, 0, 0);
        cycle(1, mk(29'h11, 4'd4, 0, 0, 64'hBEEF, 5'd2), 1, 0, 0);
        do_reset();

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            f = mk(29'($urandom), 4'($urandom_range(0, 8)), 1'($urandom),
                   1'($urandom), {32'($urandom), 32'($urandom)},
                   5'($urandom_range(0, 19)));
            cycle($urandom_range(0, 1) == 1, f, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 60) == 0, 1'($urandom));
        end
        read_fifo    = 0;
        rx_pkt_valid = 0;
        fifo_clear   = 0;
        @(posedge CAN_clk);
        #1;
        chk("scoreboard_drained", 104'(exp_q.size()), 104'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
